obs_split_59bit: RTL and testbench



---
 rtl/obs_split_59bit.sv | 140 ++++++++++++++
 tb/tb_obs_split_59bit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/obs_split_59bit.sv
// Digit-serial operand splitter: deinterleaves two 2N-bit GF(2) operands into
// even/odd N-bit halves, D bit-pairs per cycle, with valid/ready on both sides.
module obs_split_59bit #(
    parameter int N = 59,
    parameter int D = 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] a_in,
    input  logic [2*N-1:0] b_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   a_even,
    output logic [N-1:0]   a_odd,
    output logic [N-1:0]   b_even,
    output logic [N-1:0]   b_odd,
    output logic           busy
);

    localparam int NSTEPS = (N + D - 1) / D;
    localparam int CW     = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SPLIT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [2*N-1:0]   sha_reg, sha_next;
    logic [2*N-1:0]   shb_reg, shb_next;
    logic [N-1:0]     ae_reg, ae_next;
    logic [N-1:0]     ao_reg, ao_next;
    logic [N-1:0]     be_reg, be_next;
    logic [N-1:0]     bo_reg, bo_next;

    logic [D-1:0]     ae_chunk, ao_chunk, be_chunk, bo_chunk;
    logic [31:0]      base;

    // The low 2D bits of each shift register hold the pairs for this step.
    generate
        for (genvar gi = 0; gi < D; gi++) begin : g_chunk
            assign ae_chunk[gi] = sha_reg[2*gi];
            assign ao_chunk[gi] = sha_reg[2*gi+1];
            assign be_chunk[gi] = shb_reg[2*gi];
            assign bo_chunk[gi] = shb_reg[2*gi+1];
        end
    endgenerate

    assign base = 32'(cnt_reg) * 32'(D);

    // Bits pushed past N-1 on the last (partial) step fall off the top.
    function automatic logic [N-1:0] place(input logic [D-1:0] chunk,
                                           input logic [31:0]  sh);
        logic [N-1:0] t;
        t         = '0;
        t[D-1:0]  = chunk;
        return t << sh;
    endfunction

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        sha_next   = sha_reg;
        shb_next   = shb_reg;
        ae_next    = ae_reg;
        ao_next    = ao_reg;
        be_next    = be_reg;
        bo_next    = bo_reg;
        case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    sha_next   = a_in;
                    shb_next   = b_in;
                    ae_next    = '0;
                    ao_next    = '0;
                    be_next    = '0;
                    bo_next    = '0;
                    cnt_next   = '0;
                    state_next = SPLIT;
                end
            end
            SPLIT: begin
                ae_next  = ae_reg | place(ae_chunk, base);
                ao_next  = ao_reg | place(ao_chunk, base);
                be_next  = be_reg | place(be_chunk, base);
                bo_next  = bo_reg | place(bo_chunk, base);
                sha_next = sha_reg >> (2*D);
                shb_next = shb_reg >> (2*D);
                if (cnt_reg == CW'(NSTEPS - 1)) begin
                    state_next = DONE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
            sha_reg   <= '0;
            shb_reg   <= '0;
            ae_reg    <= '0;
            ao_reg    <= '0;
            be_reg    <= '0;
            bo_reg    <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            sha_reg   <= sha_next;
            shb_reg   <= shb_next;
            ae_reg    <= ae_next;
            ao_reg    <= ao_next;
            be_reg    <= be_next;
            bo_reg    <= bo_next;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg != IDLE);
    assign a_even    = ae_reg;
    assign a_odd     = ao_reg;
    assign b_even    = be_reg;
    assign b_odd     = bo_reg;

endmodule

// File: tb/tb_obs_split_59bit.sv
// Directed and randomized checks of obs_split_59bit against a bitwise
// deinterleave model.
module tb_obs_split_59bit;

    localparam int N  = 59;
    localparam int D  = 8;
    localparam int NS = (N + D - 1) / D;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [2*N-1:0] a_in = '0;
    logic [2*N-1:0] b_in = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [N-1:0]   a_even, a_odd, b_even, b_odd;
    logic           busy;

    int errors = 0;
    int checks = 0;
    int n_in   = 0;
    int n_out  = 0;
    int exp_in = 0;
    int exp_out = 0;

    obs_split_59bit #(.N(N), .D(D)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a_in      (a_in),
        .b_in      (b_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a_even    (a_even),
        .a_odd     (a_odd),
        .b_even    (b_even),
        .b_odd     (b_odd),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            if (in_valid && in_ready) n_in <= n_in + 1;
            if (out_valid && out_ready) n_out <= n_out + 1;
        end
    end

    function automatic logic [N-1:0] deint(input logic [2*N-1:0] v, input int odd);
        logic [N-1:0] r;
        for (int k = 0; k < N; k++) r[k] = v[2*k + odd];
        return r;
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] rand_op();
        logic [2*N-1:0] v;
        for (int w = 0; w < 4; w++) v[w*32 +: 22] = 22'($urandom);
        for (int w = 0; w < 3; w++) v[w*32+22 +: 10] = 10'($urandom);
        v[118-1:96] = 22'($urandom);
        return v;
    endfunction

    // One full transaction: accept, wait for results, optionally stall, drain.
    task automatic run_op(input logic [2*N-1:0] a, input logic [2*N-1:0] b,
                          input int hold, input bit junk, input bit detail);
        int lat;
        logic [N-1:0] xae, xao, xbe, xbo;
        xae = deint(a, 0); xao = deint(a, 1);
        xbe = deint(b, 0); xbo = deint(b, 1);
        check("ready_before_accept", 128'(in_ready), 128'(1));
        in_valid = 1'b1; a_in = a; b_in = b;
        @(posedge clk); #1;
        exp_in++;
        in_valid = 1'b0;
        if (detail) check("busy_after_accept", 128'(busy), 128'(1));
        lat = 0;
        while (!out_valid && lat < 200) begin
            if (junk) begin
                in_valid = 1'($urandom);
                a_in = rand_op(); b_in = rand_op();
            end
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check("out_valid_timeout", 128'(0), 128'(1));
            return;
        end
        check("latency", 128'(lat), 128'(NS));
        check("a_even", 128'(a_even), 128'(xae));
        check("a_odd",  128'(a_odd),  128'(xao));
        check("b_even", 128'(b_even), 128'(xbe));
        check("b_odd",  128'(b_odd),  128'(xbo));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            if (detail) begin
                check("hold_valid", 128'(out_valid), 128'(1));
                check("hold_ready", 128'(in_ready), 128'(0));
                check("hold_a_even", 128'(a_even), 128'(xae));
                check("hold_b_odd", 128'(b_odd), 128'(xbo));
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        exp_out++;
        out_ready = 1'b0;
        check("drain_valid", 128'(out_valid), 128'(0));
        check("drain_ready", 128'(in_ready), 128'(1));
        if (detail) check("idle_keeps_a_odd", 128'(a_odd), 128'(xao));
    endtask

    initial begin
        logic [2*N-1:0] ones, evens;
        ones  = '1;
        evens = {N{2'b01}};

        // Reset state while rst is held
        #12;
        check("rst_a_even", 128'(a_even), 128'(0));
        check("rst_b_odd", 128'(b_odd), 128'(0));
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_in_ready", 128'(in_ready), 128'(1));
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Deinterleave pattern with explicit constants
        run_op(ones, evens, 0, 0, 1);
        check("pat_a_even", 128'(a_even), 128'(59'h7FF_FFFF_FFFF_FFFF));
        check("pat_a_odd",  128'(a_odd),  128'(59'h7FF_FFFF_FFFF_FFFF));
        check("pat_b_even", 128'(b_even), 128'(59'h7FF_FFFF_FFFF_FFFF));
        check("pat_b_odd",  128'(b_odd),  128'(0));

        // Top and bottom bit positions (partial last step)
        run_op(118'(1) << 117, 118'(1), 0, 0, 1);
        check("edge_a_odd",  128'(a_odd),  128'(59'(1) << 58));
        check("edge_a_even", 128'(a_even), 128'(0));
        check("edge_b_even", 128'(b_even), 128'(1));

        // Backpressure then immediate re-accept on the following edge
        run_op(rand_op(), rand_op(), 5, 1, 1);
        run_op(rand_op(), rand_op(), 0, 0, 1);

        // Reset in the middle of a split
        in_valid = 1'b1; a_in = ones; b_in = ones;
        @(posedge clk); #1;
        exp_in++;
        in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("mid_busy_before", 128'(busy), 128'(1));
        rst = 1'b1;
        #1;
        check("mid_rst_a_even", 128'(a_even), 128'(0));
        check("mid_rst_b_odd", 128'(b_odd), 128'(0));
        check("mid_rst_valid", 128'(out_valid), 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_rst_ready", 128'(in_ready), 128'(1));
        run_op(evens, ones, 1, 0, 1);

        // Random regression with idle gaps and stalls
        for (int t = 0; t < 1000; t++) begin
            int gap;
            gap = int'($urandom_range(0, 2));
            repeat (gap) begin @(posedge clk); #1; end
            run_op(rand_op(), rand_op(), int'($urandom_range(0, 3)), 1'($urandom), 0);
        end

        @(posedge clk); #1;
        check("accept_count", 128'(n_in), 128'(exp_in));
        check("result_count", 128'(n_out), 128'(exp_out));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
